// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter/sequencer sharing one 8-bit ALU among NREQ requesters
// Optional illegal-opcode reporting on rsp_err when ALU_OPCHECK_EN is defined.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0] req_sel,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_result,
`ifdef ALU_OPCHECK_EN
  output logic              rsp_err,
`endif
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_sel,
  input  logic [7:0]        alu_result,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [2:0]      alu_sel_q, alu_sel_d;
  logic [7:0]      rsp_result_q, rsp_result_d;
`ifdef ALU_OPCHECK_EN
  logic            err_q, err_d;
`endif

  logic            grant_any;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW:0]   sum;
  logic            accept;

  // Scan from the far end back to ptr so the closest valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(NREQ)) sum = sum - (IDXW+1)'(NREQ);
      if (req_valid[sum[IDXW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[IDXW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_result_d = rsp_result_q;
`ifdef ALU_OPCHECK_EN
    err_d        = err_q;
`endif
    req_ready    = '0;
    accept       = (state_q == S_IDLE) && grant_any && !rst;
    if (accept) req_ready[grant_idx] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          alu_a_d   = req_a[int'(grant_idx)*8 +: 8];
          alu_b_d   = req_b[int'(grant_idx)*8 +: 8];
          alu_sel_d = req_sel[int'(grant_idx)*3 +: 3];
          owner_d   = grant_idx;
          ptr_d     = (grant_idx == IDXW'(NREQ-1)) ? '0 : grant_idx + IDXW'(1);
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d = alu_result;
`ifdef ALU_OPCHECK_EN
        err_d = (alu_sel_q >= 3'd5);
        if (alu_sel_q >= 3'd5) rsp_result_d = 8'h00;
`endif
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_result_q <= '0;
`ifdef ALU_OPCHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_result_q <= rsp_result_d;
`ifdef ALU_OPCHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign rsp_valid  = (state_q == S_RESP) ? (NREQ'(1) << owner_q) : '0;
  assign rsp_result = rsp_result_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign busy       = (state_q != S_IDLE);
`ifdef ALU_OPCHECK_EN
  assign rsp_err    = (state_q == S_RESP) && err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a cycle-countdown reference model
// Honours ALU_OPCHECK_EN when defined.
module tb_alu_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic [3*NREQ-1:0] req_sel = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_result;
  logic [7:0]        alu_a, alu_b, alu_result;
  logic [2:0]        alu_sel;
  logic              busy;
`ifdef ALU_OPCHECK_EN
  logic              rsp_err;
`endif

  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_sel);

  alu_arbiter #(.NREQ(NREQ), .IDXW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
`ifdef ALU_OPCHECK_EN
    .rsp_err(rsp_err),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int find_grant(input logic [NREQ-1:0] v, input int p);
    int g;
    g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && v[(p + k) % NREQ]) g = (p + k) % NREQ;
    return g;
  endfunction

  // Reference: m_left counts the cycles until the block is free again.
  int         m_left = 0;
  int         m_ptr = 0;
  int         m_owner = 0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0, m_res_pend = '0;
  logic [2:0] m_sel = '0;
  logic       m_err_pend = 1'b0;

  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_left = 0; m_ptr = 0; m_owner = 0;
      m_a = '0; m_b = '0; m_sel = '0; m_res = '0;
    end else if (m_left == 0) begin
      g = find_grant(req_valid, m_ptr);
      if (g >= 0) begin
        m_owner    = g;
        m_a        = req_a[8*g +: 8];
        m_b        = req_b[8*g +: 8];
        m_sel      = req_sel[3*g +: 3];
        m_res_pend = alu_fn(m_a, m_b, m_sel);
        m_err_pend = 1'b0;
`ifdef ALU_OPCHECK_EN
        if (m_sel >= 3'd5) begin m_res_pend = 8'h00; m_err_pend = 1'b1; end
`endif
        m_ptr  = (g + 1) % NREQ;
        m_left = 2;
      end
    end else begin
      m_left--;
      if (m_left == 1) m_res = m_res_pend;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] e_ready, e_rsp;
    e_ready = '0;
    g = find_grant(req_valid, m_ptr);
    if (!rst && m_left == 0 && g >= 0) e_ready[g] = 1'b1;
    e_rsp = (m_left == 1) ? (NREQ'(1) << m_owner) : '0;
    chk("m_req_ready", req_ready, e_ready);
    chk("m_rsp_valid", rsp_valid, e_rsp);
    chk("m_rsp_result", rsp_result, m_res);
    chk("m_busy", busy, m_left != 0);
    chk("m_alu_a", alu_a, m_a);
    chk("m_alu_b", alu_b, m_b);
    chk("m_alu_sel", alu_sel, m_sel);
`ifdef ALU_OPCHECK_EN
    chk("m_rsp_err", rsp_err, (m_left == 1) && m_err_pend);
`endif
  end

  task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sel, input logic [7:0] res);
    @(posedge clk); #2;
    req_a[8*idx +: 8] = a; req_b[8*idx +: 8] = b; req_sel[3*idx +: 3] = sel;
    req_valid = NREQ'(1) << idx;
    @(negedge clk);
    chk("op_ready", req_ready, NREQ'(1) << idx);
    @(posedge clk); #2;
    req_valid = '0;
    @(negedge clk);
    chk("op_exec_busy", busy, 1);
    chk("op_alu_a", alu_a, a);
    chk("op_alu_sel", alu_sel, sel);
    @(negedge clk);
    chk("op_rsp_valid", rsp_valid, NREQ'(1) << idx);
    chk("op_rsp_result", rsp_result, res);
`ifdef ALU_OPCHECK_EN
    chk("op_rsp_err", rsp_err, sel >= 3'd5);
`endif
    @(negedge clk);
    chk("op_idle_busy", busy, 0);
    chk("op_hold_result", rsp_result, res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, c1, c3;
    int ord[8];
    logic [7:0] res[8];
    int exp_ord[5];
    logic [7:0] exp_res[4];
    exp_ord = '{0, 1, 2, 3, 0};
    exp_res = '{8'h30, 8'h40, 8'h30, 8'h3F};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_result", rsp_result, 0);
    @(posedge clk); #2; rst = 1'b0;

    run_op(2, 8'h3C, 8'h05, 3'b000, 8'h41);
    run_op(0, 8'hF0, 8'h20, 3'b000, 8'h10);
    run_op(0, 8'h05, 8'h0A, 3'b001, 8'hFB);
    run_op(0, 8'hA5, 8'h00, 3'b100, 8'h5A);
    run_op(1, 8'hFF, 8'h00, 3'b110, 8'h00);

    // Reset mid-EXEC with requester 1 in flight; ptr is 2 here so a grant to 0 proves the reset.
    @(posedge clk); #2;
    req_a[15:8] = 8'h11; req_b[15:8] = 8'h22; req_sel[5:3] = 3'd0; req_valid = 4'b0010;
    @(posedge clk); #2;
    rst = 1'b1; req_valid = 4'b1001;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0001);
    @(posedge clk); #2; req_valid = '0;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) c0++;
      if (rsp_valid[1]) c1++;
    end
    chk("post_rst_rsp0", c0, 1);
    chk("post_rst_no_rsp1", c1, 0);

    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    req_a = {8'h0F, 8'hF0, 8'h50, 8'h10};
    req_b = {8'h30, 8'h3C, 8'h10, 8'h20};
    req_sel = {3'd3, 3'd2, 3'd1, 3'd0};
    req_valid = 4'b1111;
    n = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rsp_valid != 0 && n < 8) begin
        for (int k = 0; k < NREQ; k++) if (rsp_valid[k]) ord[n] = k;
        res[n] = rsp_result;
        n++;
      end
    end
    @(posedge clk); #2; req_valid = '0;
    chk("rr_count", n, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_order%0d", i), ord[i], exp_ord[i]);
      chk($sformatf("rr_result%0d", i), res[i], exp_res[exp_ord[i]]);
    end
    repeat (4) @(posedge clk);

    #2; req_valid = 4'b1000;
    @(negedge clk);
    chk("wd_ready3", req_ready, 4'b1000);
    #1; req_valid = 4'b0000;
    @(posedge clk); #2; req_valid = 4'b0010;
    @(negedge clk);
    chk("wd_ready1", req_ready, 4'b0010);
    @(posedge clk); #2; req_valid = '0;
    c1 = 0; c3 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) c1++;
      if (rsp_valid[3]) c3++;
    end
    chk("wd_rsp1", c1, 1);
    chk("wd_no_rsp3", c3, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit combinational ALU among NREQ requesters.
- ALU opcodes:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 NOT A
  - others return 0
- The block accepts one request at a time through a valid/ready handshake, registers the operands onto the ALU inputs, captures the ALU result, and returns it to the winning requester with a one-cycle response strobe.
- Sits between the requesting engines and the shared ALU instance. The ALU ports are external.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDXW, 2, width of the grant index; must equal clog2(NREQ).

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit set.
- req_a  in  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- req_b  in  8*NREQ  operand B, same packing.
- req_sel  in  3*NREQ  opcode; requester i uses bits [3i+2:3i].
- rsp_valid  out  NREQ  one-hot, one-cycle result strobe to the originating requester.
- rsp_result  out  8  result; valid while rsp_valid is nonzero; holds its value otherwise.
- rsp_err  out  1  illegal-opcode flag; only present when ALU_OPCHECK_EN is defined.
- alu_a  out  8  operand A to the shared ALU.
- alu_b  out  8  operand B to the shared ALU.
- alu_sel  out  3  opcode to the shared ALU.
- alu_result  in  8  combinational ALU result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE and the round-robin pointer goes to 0.
  - req_ready, rsp_valid, rsp_result, rsp_err, alu_a, alu_b, alu_sel and busy are all 0.
  - An in-flight operation is discarded and no response is issued.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. There are no other states; all transitions are unconditional except leaving IDLE.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching ptr, ptr+1, ... with wrap modulo NREQ.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - If no request is valid, req_ready=0 and the block stays in IDLE.
  - Acceptance happens on an edge where req_valid[g] and req_ready[g] are both high. On that edge:
    - alu_a, alu_b and alu_sel load requester g's fields.
    - g is stored as the owner.
    - ptr becomes (g+1) mod NREQ.
    - The state moves to EXEC.
- EXEC:
  - The ALU inputs are stable for one full cycle and req_ready=0.
  - At the end of the cycle, rsp_result loads alu_result and the state moves to RESP.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle and req_ready=0; then the state returns to IDLE.
  - No new acceptance is possible in RESP.
- alu_a, alu_b and alu_sel hold their last values in IDLE and RESP. They change only on acceptance.
- Latency: acceptance on edge T gives rsp_valid high in cycle T+2. Throughput is one operation per 3 cycles.
- Handshake rules:
  - A requester may drop req_valid before it is accepted; no transaction occurs.
  - Operand changes while not accepted are permitted and take effect at acceptance.
  - A requester holding req_valid across its own response is treated as a new request. It competes normally; the rotation places it last after a grant.
- Fairness: with all NREQ requesters continuously valid, grants are issued in order ptr, ptr+1, ... Every requester is served within NREQ operations.
- Width rules:
  - The ALU result is 8 bits: carry out of ADD is dropped and SUB borrow wraps. The arbiter does not modify the result.
- Simultaneous events: rst takes priority over everything. A requester that sees req_ready in the same cycle its valid falls is not accepted.

Optional Feature:
- Macro: ALU_OPCHECK_EN.
- Defined:
  - sel values 101, 110 and 111 are still accepted and sequenced normally with identical latency.
  - Their response has rsp_result=0 and rsp_err=1, asserted coincident with rsp_valid.
  - alu_sel is still driven with the raw opcode.
  - rsp_err is 0 in all other cycles.
- Not defined:
  - The rsp_err port is absent.
  - Illegal opcodes return whatever the ALU produces; the shared ALU returns 0.

Test Plan:
- Reset: assert rst mid-EXEC with requester 1 in flight -> all outputs 0 immediately, no rsp_valid afterward, next grant starts from requester 0.
- Single request: req 2 presents A=0x3C, B=0x05, sel=000 -> accepted at T; alu_a=0x3C at T+1; rsp_valid=4'b0100, rsp_result=0x41 at T+2; busy high T+1..T+2.
- Wrap arithmetic: req 0 ADD 0xF0+0x20 -> 0x10; req 0 SUB 0x05-0x0A -> 0xFB; req 0 NOT A=0xA5 -> 0x5A.
- Round-robin: all four requesters valid continuously, ptr=0 -> grant order 0,1,2,3,0. Each rsp_valid bit pulses once per 12 cycles, and rsp_result matches the requester's operation.
- Withdrawal: req 3 raises valid in IDLE then drops it before a clock edge; req 1 raises valid next cycle -> only req 1 is served; no rsp_valid[3].
- ALU_OPCHECK_EN: req 1 sel=110, A=0xFF -> rsp_valid=4'b0010, rsp_result=0x00, rsp_err=1 at T+2. Without the macro, the same stimulus gives rsp_result=0x00 and no rsp_err port.
